// File: rtl/prio_rr_arbiter_8.sv
// rtl/prio_rr_arbiter_8.sv - 8-requester arbiter with registered one-hot grant, hold timeout and rotating priority
// Optional feature macro: ARB_ROUND_ROBIN_EN (defined: rotating pointer; undefined: fixed highest-index priority)
module prio_rr_arbiter_8 #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic [7:0]     hold_q, hold_d;
    logic           timeout_q, timeout_d;
    logic [7:0]     hold_inc;
    logic [IDW-1:0] ptr;
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic           release_now;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = {IDW{1'b1}};
`endif

    // Descending scan from ptr; index arithmetic wraps naturally at IDW bits.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < N; i++) begin
            if (!win_found && req[ptr - IDW'(i)]) begin
                win_found = 1'b1;
                win_id    = ptr - IDW'(i);
            end
        end
    end

    assign hold_inc    = hold_q + 8'd1;
    assign release_now = done || !req[id_q] || (hold_inc == HOLD_LIMIT);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_id;
                    id_d    = win_id;
                    hold_d  = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = win_id - IDW'(1);
`endif
                end
            end
            GRANT: begin
                hold_d = hold_inc;
                if (release_now) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    id_d      = '0;
                    hold_d    = '0;
                    // Only a pure hold-limit release counts as a timeout.
                    timeout_d = !done && req[id_q];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            id_q      <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q     <= {IDW{1'b1}};
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_prio_rr_arbiter_8.sv
// tb/tb_prio_rr_arbiter_8.sv - scoreboard bench for prio_rr_arbiter_8 (MAX_HOLD=4)
module tb_prio_rr_arbiter_8;

    localparam int MAXH = 4;

    typedef struct {
        logic [2:0] id;
        int         len;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    prio_rr_arbiter_8 #(.N(8), .IDW(3), .MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] id, input int len, input logic to);
        exp_t e;
        e.id  = id;
        e.len = len;
        e.to  = to;
        sb.push_back(e);
    endtask

    task automatic grant_done(input int len);
        tick();
        repeat (len - 1) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, int'(gnt), 0);
        chk({tag, "_gnt_id"}, int'(gnt_id), 0);
        chk({tag, "_gnt_valid"}, int'(gnt_valid), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
    endtask

    // Monitor: tracks each grant session and compares it with the scoreboard head.
    bit   in_sess = 1'b0;
    int   cnt     = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (rst) begin
            if (in_sess) begin
                chk("rst_abort_len", cnt, cur.len);
                in_sess = 1'b0;
            end
        end else begin
            chk("valid_vs_gnt", int'(gnt_valid), int'(gnt != 8'h00));
            chk("onehot", int'($onehot0(gnt)), 1);
            if (gnt_valid && !in_sess) begin
                if (sb.size() == 0) begin
                    chk("unexpected_grant_id", int'(gnt_id), -1);
                    cur.id = gnt_id; cur.len = -1; cur.to = 1'b0;
                end else begin
                    cur = sb.pop_front();
                end
                in_sess = 1'b1;
                cnt     = 1;
                chk("grant_id", int'(gnt_id), int'(cur.id));
                chk("grant_vec", int'(gnt), int'(8'd1 << cur.id));
                chk("timeout_in_grant", int'(timeout), 0);
            end else if (gnt_valid && in_sess) begin
                cnt++;
                chk("grant_id_hold", int'(gnt_id), int'(cur.id));
                chk("timeout_in_grant", int'(timeout), 0);
            end else if (!gnt_valid && in_sess) begin
                in_sess = 1'b0;
                chk("grant_len", cnt, cur.len);
                chk("release_timeout", int'(timeout), int'(cur.to));
                chk("idle_gnt_id", int'(gnt_id), 0);
            end else begin
                chk("idle_timeout", int'(timeout), 0);
                chk("idle_gnt_id", int'(gnt_id), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        repeat (2) tick();
        chk_zero("reset");
        rst = 1'b0;

        // Asynchronous reset mid-grant, then first grant after reset is 7
        req = 8'h81;
        push(3'd7, 2, 1'b0);
        tick();
        tick();
        #6;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        tick();
        tick();
        rst = 1'b0;
        push(3'd7, 2, 1'b0);
        tick();
        tick();
        req = 8'h01;
        tick();
        push(3'd0, 1, 1'b0);
        grant_done(1);
        req = 8'h00;
        tick();

        // Single requester handshake, with a non-owner request raised mid-grant
        req = 8'h04;
        push(3'd2, 3, 1'b0);
        tick();
        req = 8'h84;
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        push(3'd7, 1, 1'b0);
        grant_done(1);
        req = 8'h00;
        tick();

        // done while idle is ignored
        done = 1'b1;
        repeat (2) tick();
        done = 1'b0;
        tick();

        // All requesting, each grant ended after one cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            push(3'((7 - k) & 7), 1, 1'b0);
`else
            push(3'd7, 1, 1'b0);
`endif
            grant_done(1);
        end
        req = 8'h00;
        tick();

        // Forced release after MAX_HOLD, idle cycle, re-grant, then drop on cycle 2
        req = 8'h10;
        push(3'd4, MAXH, 1'b1);
        push(3'd4, 2, 1'b0);
        repeat (MAXH + 1) tick();
        tick();
        tick();
        req = 8'h00;
        tick();
        tick();

        // done coincident with hold limit: normal release
        req = 8'h10;
        push(3'd4, MAXH, 1'b0);
        repeat (MAXH) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        tick();

        // request drop coincident with hold limit: normal release
        req = 8'h10;
        push(3'd4, MAXH, 1'b0);
        repeat (MAXH) tick();
        req = 8'h00;
        tick();
        repeat (3) tick();

        chk("sb_drained", sb.size(), 0);
        chk("no_open_session", int'(in_sess), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
